// File: rtl/cipher_pkg.sv
// Shared definitions for the multi-LFSR stream cipher link.
// Used by both the receive deframer and the transmit encryptor.
package cipher_pkg;

  localparam int          WARMUP        = 16;
  localparam logic [7:0]  SYNC_BYTE     = 8'h5A;
  localparam logic [7:0]  ZERO_SEED_SUB = 8'h01;

  // Feedback taps: L1 b7^b5^b4^b3, L2 b7^b6^b5^b0, L3 b7^b5^b4^b2
  localparam logic [7:0]  TAP_L1 = 8'hB8;
  localparam logic [7:0]  TAP_L2 = 8'hE1;
  localparam logic [7:0]  TAP_L3 = 8'hB4;

  typedef enum logic [2:0] {
    S_HUNT,
    S_IV1,
    S_IV2,
    S_IV3,
    S_LEN,
    S_WARM,
    S_DATA
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] lfsr_step(
    input logic [7:0] v,
    input logic [7:0] taps
  );
    return {v[6:0], ^(v & taps)};
  endfunction

  // An all-zero LFSR would lock up, so it is replaced.
  function automatic logic [7:0] fix_seed(input logic [7:0] s);
    return (s == 8'h00) ? ZERO_SEED_SUB : s;
  endfunction

endpackage

// File: rtl/keystream_gen.sv
// Three Fibonacci LFSRs combined by XOR and whitened through the AES S-box.
// Shared unchanged between the transmit encryptor and the receive deframer.
module keystream_gen
  import cipher_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] seed1,
  input  logic [7:0] seed2,
  input  logic [7:0] seed3,
  input  logic       step,
  output logic [7:0] ks
);

  logic [7:0] l1_q, l1_d;
  logic [7:0] l2_q, l2_d;
  logic [7:0] l3_q, l3_d;

  always_comb begin
    l1_d = l1_q;
    l2_d = l2_q;
    l3_d = l3_q;
    if (load) begin
      l1_d = seed1;
      l2_d = seed2;
      l3_d = seed3;
    end else if (step) begin
      l1_d = lfsr_step(l1_q, TAP_L1);
      l2_d = lfsr_step(l2_q, TAP_L2);
      l3_d = lfsr_step(l3_q, TAP_L3);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l1_q <= '0;
      l2_q <= '0;
      l3_q <= '0;
    end else begin
      l1_q <= l1_d;
      l2_q <= l2_d;
      l3_q <= l3_d;
    end
  end

  assign ks = SBOX[l1_q ^ l2_q ^ l3_q];

endmodule

// File: rtl/cipher_rx_deframer.sv
// Receive deframer: hunts for SYNC, seeds the keystream from key^IV,
// warms it up and decrypts the payload into a registered output stage.
module cipher_rx_deframer
  import cipher_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key1,
  input  logic [7:0] key2,
  input  logic [7:0] key3,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_done,
  output logic       err_len,
  output logic       busy
);

  localparam int             WARM_W    = $clog2(WARMUP);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);

  state_t            state_q, state_d;
  logic [7:0]        iv1_q, iv1_d;
  logic [7:0]        iv2_q, iv2_d;
  logic [7:0]        iv3_q, iv3_d;
  logic [7:0]        rem_q, rem_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic [7:0]        odata_q, odata_d;
  logic              ovalid_q, ovalid_d;
  logic              olast_q, olast_d;
  logic              errl_q, errl_d;

  logic       accept;
  logic       ks_load;
  logic       ks_step;
  logic [7:0] ks;

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_HUNT, S_IV1, S_IV2,
        S_IV3, S_LEN: in_ready = 1'b1;
        S_DATA:       in_ready = !ovalid_q || out_ready;
        default:      in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    iv1_d    = iv1_q;
    iv2_d    = iv2_q;
    iv3_d    = iv3_q;
    rem_d    = rem_q;
    warm_d   = warm_q;
    odata_d  = odata_q;
    ovalid_d = ovalid_q;
    olast_d  = olast_q;
    errl_d   = 1'b0;
    ks_load  = 1'b0;
    ks_step  = 1'b0;

    // Drain happens in any state; a DATA accept below reloads it.
    if (ovalid_q && out_ready) begin
      ovalid_d = 1'b0;
      olast_d  = 1'b0;
    end

    unique case (state_q)
      S_HUNT: begin
        if (accept && in_data == SYNC_BYTE) state_d = S_IV1;
      end
      S_IV1: begin
        if (accept) begin
          iv1_d   = in_data;
          state_d = S_IV2;
        end
      end
      S_IV2: begin
        if (accept) begin
          iv2_d   = in_data;
          state_d = S_IV3;
        end
      end
      S_IV3: begin
        if (accept) begin
          iv3_d   = in_data;
          ks_load = 1'b1;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (accept) begin
          rem_d  = in_data;
          warm_d = '0;
          if (in_data == 8'h00) begin
            errl_d  = 1'b1;
            state_d = S_HUNT;
          end else begin
            state_d = S_WARM;
          end
        end
      end
      S_WARM: begin
        ks_step = 1'b1;
        warm_d  = warm_q + 1'b1;
        if (warm_q == WARM_LAST) state_d = S_DATA;
      end
      S_DATA: begin
        if (accept) begin
          odata_d  = in_data ^ ks;
          ovalid_d = 1'b1;
          olast_d  = (rem_q == 8'd1);
          rem_d    = rem_q - 8'd1;
          ks_step  = 1'b1;
          if (rem_q == 8'd1) state_d = S_HUNT;
        end
      end
      default: state_d = S_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_HUNT;
      iv1_q    <= '0;
      iv2_q    <= '0;
      iv3_q    <= '0;
      rem_q    <= '0;
      warm_q   <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
      errl_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      iv1_q    <= iv1_d;
      iv2_q    <= iv2_d;
      iv3_q    <= iv3_d;
      rem_q    <= rem_d;
      warm_q   <= warm_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
      errl_q   <= errl_d;
    end
  end

  keystream_gen u_ks (
    .clk   (clk),
    .rst   (rst),
    .load  (ks_load),
    .seed1 (fix_seed(key1 ^ iv1_q)),
    .seed2 (fix_seed(key2 ^ iv2_q)),
    .seed3 (fix_seed(key3 ^ in_data)),
    .step  (ks_step),
    .ks    (ks)
  );

  assign out_data   = odata_q;
  assign out_valid  = ovalid_q;
  assign out_last   = olast_q;
  assign err_len    = errl_q;
  assign busy       = (state_q != S_HUNT);
  assign frame_done = !rst && ovalid_q && out_ready && olast_q;

endmodule

// File: tb/tb_cipher_rx_deframer.sv
// Scoreboard bench for cipher_rx_deframer with a GF(2^8)-derived S-box
// and a frame-level keystream model.
module tb_cipher_rx_deframer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] key1, key2, key3;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_done;
  logic       err_len;
  logic       busy;

  cipher_rx_deframer dut (
    .clk        (clk),
    .rst        (rst),
    .key1       (key1),
    .key2       (key2),
    .key3       (key3),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .frame_done (frame_done),
    .err_len    (err_len),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       last;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [7:0] fixed_pl[$];
  logic [7:0] sbox_m[256];
  logic [7:0] ks_m[256];
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int frames_exp = 0;
  int rdy_mode = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b};
    t = t << n;
    return t[15:8];
  endfunction

  function automatic void build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                ^ rotl(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [7:0] lstep(input logic [7:0] v, input int a,
                                       input int b, input int c, input int d);
    return {v[6:0], v[a] ^ v[b] ^ v[c] ^ v[d]};
  endfunction

  function automatic void gen_ks(input logic [7:0] i1, input logic [7:0] i2,
                                 input logic [7:0] i3, input int n);
    logic [7:0] s1 = key1 ^ i1;
    logic [7:0] s2 = key2 ^ i2;
    logic [7:0] s3 = key3 ^ i3;
    if (s1 == 0) s1 = 8'h01;
    if (s2 == 0) s2 = 8'h01;
    if (s3 == 0) s3 = 8'h01;
    for (int i = 0; i < 16 + n; i++) begin
      if (i >= 16) ks_m[i-16] = sbox_m[s1 ^ s2 ^ s3];
      s1 = lstep(s1, 7, 5, 4, 3);
      s2 = lstep(s2, 7, 6, 5, 0);
      s3 = lstep(s3, 7, 5, 4, 2);
    end
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  end

  logic [7:0] h_data;
  logic       h_last;
  logic       h_stall = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      h_stall = 1'b0;
    end else begin
      if (h_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(h_data));
        chk("hold_last", 32'(out_last), 32'(h_last));
      end
      if (frame_done) done_cnt++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got %0h expected none", out_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_last", 32'(out_last), 32'(e.last));
          chk("frame_done", 32'(frame_done), 32'(e.last));
        end
      end else if (frame_done) begin
        chk("stray_frame_done", 32'(frame_done), 32'd0);
      end
      h_stall = out_valid && !out_ready;
      h_data  = out_data;
      h_last  = out_last;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int  n = 0;
    bit  acc;
    if (gaps)
      while ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 1000) begin
        chk("accept_timeout", 32'(n), 32'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] i1, input logic [7:0] i2,
                            input logic [7:0] i3, input int len,
                            input bit gaps, input int abort_at);
    int         cnt = 0;
    bit         seen = 0;
    logic [7:0] p;
    gen_ks(i1, i2, i3, len);
    send_byte(8'h5A, gaps);
    send_byte(i1, gaps);
    send_byte(i2, gaps);
    send_byte(i3, gaps);
    send_byte(8'(len), gaps);
    if (len == 0) begin
      chk("err_len_pulse", 32'(err_len), 32'd1);
      chk("busy_after_len0", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      chk("err_len_clear", 32'(err_len), 32'd0);
      return;
    end
    for (int g = 0; g < 40 && !seen; g++) begin
      @(negedge clk);
      if (in_ready) seen = 1;
      else cnt++;
      @(posedge clk);
      #1;
    end
    chk("warm_cycles", 32'(cnt), 32'd16);
    for (int i = 0; i < len; i++) begin
      if (i == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        return;
      end
      p = (fixed_pl.size() > 0) ? fixed_pl.pop_front() : 8'($urandom);
      sb.push_back('{d: p, last: (i == len - 1)});
      send_byte(p ^ ks_m[i], gaps);
    end
    frames_exp++;
  endtask

  initial begin
    int wait_n;
    build_sbox();
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    key1 = 8'hAA;
    key2 = 8'hCC;
    key3 = 8'hF0;
    rst  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_out_last", 32'(out_last), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err_len", 32'(err_len), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    fixed_pl = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    send_frame(8'h0F, 8'h33, 8'h55, 4, 0, -1);

    send_byte(8'h00, 0);
    chk("hunt_busy_00", 32'(busy), 32'd0);
    send_byte(8'h12, 0);
    chk("hunt_busy_12", 32'(busy), 32'd0);
    send_byte(8'hFF, 0);
    chk("hunt_busy_ff", 32'(busy), 32'd0);
    send_frame(8'($urandom), 8'($urandom), 8'($urandom), 6, 0, -1);

    send_frame(8'h0F, 8'h33, 8'h55, 0, 0, -1);
    send_frame(8'h0F, 8'h33, 8'h55, 5, 0, -1);

    key1 = 8'h0F;
    send_frame(8'h0F, 8'($urandom), 8'($urandom), 10, 0, -1);

    rdy_mode = 1;
    send_frame(8'($urandom), 8'($urandom), 8'($urandom), 255, 1, -1);

    rdy_mode = 2;
    for (int f = 0; f < 4; f++) begin
      key2 = 8'($urandom);
      send_frame(8'($urandom), 8'($urandom), 8'($urandom),
                 $urandom_range(1, 20), 1, -1);
    end

    send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8, 0, 3);
    rdy_mode = 0;
    send_frame(8'($urandom), 8'($urandom), 8'($urandom), 7, 0, -1);

    wait_n = 0;
    while (sb.size() != 0 && wait_n < 2000) begin
      @(posedge clk);
      wait_n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("frame_done_count", 32'(done_cnt), 32'(frames_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
